// File: rtl/dither_frame_sequencer.sv
// Frame-level sequencer for the Floyd-Steinberg datapath: walks pixels in raster order and
// issues load / quantize / diffuse strobes per pixel, gated by the datapath ready handshake.
module dither_frame_sequencer #(
  parameter int unsigned IMAGEX     = 64,
  parameter int unsigned IMAGEY     = 64,
  parameter int unsigned IMAGEXlog2 = $clog2(IMAGEX),
  parameter int unsigned IMAGEYlog2 = $clog2(IMAGEY),
  parameter int unsigned ADDR_W     = IMAGEXlog2 + IMAGEYlog2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  dp_ready,
  output logic [ADDR_W-1:0]     pixel_addr,
  output logic [IMAGEXlog2-1:0] pixel_x,
  output logic [IMAGEYlog2-1:0] pixel_y,
  output logic                  store_old_p,
  output logic                  compare_and_store_n,
  output logic                  compute_fin,
  output logic                  e_valid,
  output logic                  sw_valid,
  output logic                  s_valid,
  output logic                  se_valid,
  output logic                  busy,
  output logic                  done
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_QUANT   = 3'd2;
  localparam logic [2:0] S_DIFFUSE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [IMAGEXlog2-1:0] X_LAST = IMAGEXlog2'(IMAGEX - 1);
  localparam logic [IMAGEYlog2-1:0] Y_LAST = IMAGEYlog2'(IMAGEY - 1);

  logic [2:0]            state_q, state_d;
  logic [IMAGEXlog2-1:0] x_q, x_d;
  logic [IMAGEYlog2-1:0] y_q, y_d;
  logic                  busy_q, done_q;

  // State, counters and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
    end
  end

  // Next state and phase strobes; a strobe fires only in the cycle its phase advances
  always_comb begin
    state_d             = state_q;
    x_d                 = x_q;
    y_d                 = y_q;
    store_old_p         = 1'b0;
    compare_and_store_n = 1'b0;
    compute_fin         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          x_d     = '0;
          y_d     = '0;
        end
      end
      S_LOAD: begin
        if (dp_ready) begin
          store_old_p = 1'b1;
          state_d     = S_QUANT;
        end
      end
      S_QUANT: begin
        if (dp_ready) begin
          compare_and_store_n = 1'b1;
          state_d             = S_DIFFUSE;
        end
      end
      S_DIFFUSE: begin
        if (dp_ready) begin
          compute_fin = 1'b1;
          if (x_q == X_LAST) begin
            if (y_q == Y_LAST) begin
              state_d = S_DONE;
            end else begin
              state_d = S_LOAD;
              x_d     = '0;
              y_d     = y_q + IMAGEYlog2'(1);
            end
          end else begin
            state_d = S_LOAD;
            x_d     = x_q + IMAGEXlog2'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
      default: begin
        state_d = S_IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase

    // Abort outranks both the ready handshake and frame completion
    if (abort && (state_q != S_IDLE)) begin
      state_d             = S_IDLE;
      x_d                 = '0;
      y_d                 = '0;
      store_old_p         = 1'b0;
      compare_and_store_n = 1'b0;
      compute_fin         = 1'b0;
    end
  end

  assign pixel_x    = x_q;
  assign pixel_y    = y_q;
  assign pixel_addr = ADDR_W'({y_q, x_q});

  assign e_valid  = (x_q != X_LAST);
  assign s_valid  = (y_q != Y_LAST);
  assign sw_valid = s_valid && (x_q != '0);
  assign se_valid = s_valid && e_valid;

  assign busy = busy_q;
  assign done = done_q;

endmodule
